// File: rtl/note_seq_pkg.sv
// note_seq_pkg: shared types and constants for the note sequencer.
//   state_e    : sequencer FSM states (IDLE, PLAY)
//   entry_t    : 9-bit table entry {rest, period[7:0]}
//   REST_ENTRY : reset/cleared table contents (rest flag set, period 0)
//   MIN_TEMPO  : shortest step length in clocks
//   MIN_PERIOD : smallest period that still counts as a playable note
package note_seq_pkg;

  typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_e;

  typedef struct packed {
    logic       rest;
    logic [7:0] period;
  } entry_t;

  localparam entry_t REST_ENTRY = 9'h100;
  localparam int     MIN_TEMPO  = 2;
  localparam int     MIN_PERIOD = 2;

  // Periods 0 and 1 cannot drive the downstream counter, so they play as rests.
  function automatic logic is_note(entry_t e);
    return !e.rest && (e.period >= 8'(MIN_PERIOD));
  endfunction

endpackage

// File: rtl/note_seq_if.sv
// note_seq_if: host/counter-facing bundle for note_sequencer.
//   Host -> sequencer : start, stop, tempo, gate_len, last_step,
//                       wr_en, wr_addr, wr_data
//   Sequencer -> out  : max, gate, restart, step_idx, busy
//   With NOTE_SEQ_ONESHOT_EN defined: oneshot (in) and done (out) are added.
// Modports: master = host side, slave = sequencer side.
interface note_seq_if #(
  parameter int STEPS   = 8,
  parameter int TEMPO_W = 24,
  parameter int GATE_W  = 24
);
  import note_seq_pkg::*;
  localparam int STEP_W = $clog2(STEPS);

  logic               start;
  logic               stop;
  logic [TEMPO_W-1:0] tempo;
  logic [GATE_W-1:0]  gate_len;
  logic [STEP_W-1:0]  last_step;
  logic               wr_en;
  logic [STEP_W-1:0]  wr_addr;
  entry_t             wr_data;
  logic [7:0]         max;
  logic               gate;
  logic               restart;
  logic [STEP_W-1:0]  step_idx;
  logic               busy;
`ifdef NOTE_SEQ_ONESHOT_EN
  logic               oneshot;
  logic               done;
`endif

  modport master (
    output start, stop, tempo, gate_len, last_step, wr_en, wr_addr, wr_data,
`ifdef NOTE_SEQ_ONESHOT_EN
    output oneshot,
    input  done,
`endif
    input  max, gate, restart, step_idx, busy
  );

  modport slave (
    input  start, stop, tempo, gate_len, last_step, wr_en, wr_addr, wr_data,
`ifdef NOTE_SEQ_ONESHOT_EN
    input  oneshot,
    output done,
`endif
    output max, gate, restart, step_idx, busy
  );

endinterface

// File: rtl/note_seq_table.sv
// note_seq_table: STEPS x 9-bit step table.
//   clk, reset (sync, active low: every entry returns to REST_ENTRY and
//   writes in that cycle are dropped), wr_en/wr_addr/wr_data (one write port),
//   rd_addr/rd_data (combinational read of the pre-edge contents).
module note_seq_table
  import note_seq_pkg::*;
#(
  parameter int STEPS = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [$clog2(STEPS)-1:0] wr_addr,
  input  entry_t                   wr_data,
  input  logic [$clog2(STEPS)-1:0] rd_addr,
  output entry_t                   rd_data
);

  entry_t tbl_q [STEPS];
  entry_t tbl_d [STEPS];

  always_comb begin
    tbl_d = tbl_q;
    if (wr_en) tbl_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < STEPS; i++) tbl_q[i] <= REST_ENTRY;
    end else begin
      tbl_q <= tbl_d;
    end
  end

  // Reads the current contents, so a write on a load edge only shows up
  // the next time that entry is loaded.
  assign rd_data = tbl_q[rd_addr];

endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: step sequencer feeding the synth period counter.
//   clk, reset     : system clock, synchronous active-low reset
//   bus (slave)    : start/stop control, tempo, gate_len, last_step,
//                    table write port; outputs max (period), gate,
//                    restart (onset pulse), step_idx, busy
// Optional: define NOTE_SEQ_ONESHOT_EN to add bus.oneshot / bus.done; when
// oneshot is high as step last_step ends, playback stops instead of wrapping.
module note_sequencer
  import note_seq_pkg::*;
#(
  parameter int STEPS   = 8,
  parameter int TEMPO_W = 24,
  parameter int GATE_W  = 24
) (
  input logic       clk,
  input logic       reset,
  note_seq_if.slave bus
);

  localparam int STEP_W = $clog2(STEPS);
  localparam int CW     = (TEMPO_W > GATE_W) ? TEMPO_W : GATE_W;

  state_e             state_q, state_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [7:0]         max_q, max_d;
  logic               gate_q, gate_d;
  logic               restart_q, restart_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [TEMPO_W-1:0] tick_q, tick_d;
  logic [TEMPO_W-1:0] tempo_q, tempo_d;
  logic [GATE_W-1:0]  gl_q, gl_d;

  logic [TEMPO_W-1:0] tempo_eff;
  logic [STEP_W-1:0]  ld_idx, next_idx;
  logic               load, wrap, step_end, gate_cut, finish;
  entry_t             rd_entry;

  note_seq_table #(.STEPS(STEPS)) u_table (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (bus.wr_en),
    .wr_addr(bus.wr_addr),
    .wr_data(bus.wr_data),
    .rd_addr(ld_idx),
    .rd_data(rd_entry)
  );

  assign tempo_eff = (bus.tempo < TEMPO_W'(MIN_TEMPO)) ? TEMPO_W'(MIN_TEMPO) : bus.tempo;
  assign step_end  = (state_q == PLAY) && (tick_q == tempo_q - TEMPO_W'(1));
  // >= rather than == so a last_step lowered below the playing step still wraps.
  assign wrap      = (step_q >= bus.last_step);
  assign next_idx  = wrap ? '0 : step_q + 1'b1;
  // Gate only drops inside the step for 0 < gate_len < tempo; otherwise legato.
  assign gate_cut  = (gl_q != '0) && (CW'(gl_q) < CW'(tempo_q)) &&
                     (CW'(tick_q) == CW'(gl_q) - CW'(1));

`ifdef NOTE_SEQ_ONESHOT_EN
  assign finish   = bus.oneshot && wrap;
  assign bus.done = done_q;
`else
  assign finish   = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    max_d     = max_q;
    gate_d    = gate_q;
    restart_d = 1'b0;
    done_d    = 1'b0;
    tick_d    = tick_q;
    tempo_d   = tempo_q;
    gl_d      = gl_q;
    load      = 1'b0;
    ld_idx    = '0;

    if (bus.stop) begin
      state_d = IDLE;
      gate_d  = 1'b0;
    end else if (bus.start) begin
      load = 1'b1;
    end else if (state_q == PLAY) begin
      if (step_end) begin
        if (finish) begin
          state_d = IDLE;
          gate_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          load   = 1'b1;
          ld_idx = next_idx;
        end
      end else begin
        tick_d = tick_q + 1'b1;
        if (gate_cut) gate_d = 1'b0;
      end
    end

    if (load) begin
      state_d = PLAY;
      tick_d  = '0;
      step_d  = ld_idx;
      tempo_d = tempo_eff;
      gl_d    = bus.gate_len;
      if (is_note(rd_entry)) begin
        max_d     = rd_entry.period;
        gate_d    = 1'b1;
        restart_d = 1'b1;
      end else begin
        gate_d = 1'b0;
      end
    end

    busy_d = (state_d == PLAY);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      step_q    <= '0;
      max_q     <= '0;
      gate_q    <= 1'b0;
      restart_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tick_q    <= '0;
      tempo_q   <= TEMPO_W'(MIN_TEMPO);
      gl_q      <= '0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      max_q     <= max_d;
      gate_q    <= gate_d;
      restart_q <= restart_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      tick_q    <= tick_d;
      tempo_q   <= tempo_d;
      gl_q      <= gl_d;
    end
  end

  assign bus.max      = max_q;
  assign bus.gate     = gate_q;
  assign bus.restart  = restart_q;
  assign bus.step_idx = step_q;
  assign bus.busy     = busy_q;

endmodule
